// File: rtl/axi_inst_rd_slave.sv
// AXI3 read slave for instruction fetch: in-order AR queue, burst walker over a 1-cycle
// synchronous word memory, and a 2-entry credit-managed R skid buffer.
module axi_inst_rd_slave #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned MEM_AW   = 14,
    parameter int unsigned AR_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [3:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned PtrW = $clog2(AR_DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // AR queue
    logic [ID_W-1:0]   q_id_q    [AR_DEPTH];
    logic [MEM_AW-1:0] q_waddr_q [AR_DEPTH];
    logic              q_hierr_q [AR_DEPTH];
    logic [3:0]        q_len_q   [AR_DEPTH];
    logic [2:0]        q_size_q  [AR_DEPTH];
    logic [1:0]        q_burst_q [AR_DEPTH];
    logic [PtrW-1:0]   q_wp_q, q_rp_q;
    logic [PtrW:0]     q_cnt_q;
    logic              ar_up_q;
    logic              ar_push, pop, q_nempty;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^s_araddr[1:0];

    assign s_arready = ar_up_q && (q_cnt_q != (PtrW+1)'(AR_DEPTH));
    assign ar_push   = s_arvalid && s_arready;
    assign q_nempty  = (q_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_wp_q  <= '0;
            q_rp_q  <= '0;
            q_cnt_q <= '0;
            ar_up_q <= 1'b0;
        end else begin
            ar_up_q <= 1'b1;
            if (ar_push) begin
                q_id_q[q_wp_q]    <= s_arid;
                q_waddr_q[q_wp_q] <= s_araddr[MEM_AW+1:2];
                q_hierr_q[q_wp_q] <= |s_araddr[31:MEM_AW+2];
                q_len_q[q_wp_q]   <= s_arlen;
                q_size_q[q_wp_q]  <= s_arsize;
                q_burst_q[q_wp_q] <= s_arburst;
                q_wp_q            <= q_wp_q + PtrW'(1);
            end
            if (pop) q_rp_q <= q_rp_q + PtrW'(1);
            q_cnt_q <= q_cnt_q + (PtrW+1)'(ar_push) - (PtrW+1)'(pop);
        end
    end

    // Response code for the queue head
    logic [3:0] h_len;
    logic [1:0] h_burst, h_resp;
    logic       h_wrap_ok, h_slverr;
    always_comb begin
        h_len     = q_len_q[q_rp_q];
        h_burst   = q_burst_q[q_rp_q];
        h_wrap_ok = (h_len == 4'd1) || (h_len == 4'd3) || (h_len == 4'd7) || (h_len == 4'd15);
        h_slverr  = (q_size_q[q_rp_q] != 3'b010) || (h_burst == 2'b11) ||
                    ((h_burst == 2'b10) && !h_wrap_ok);
        h_resp    = q_hierr_q[q_rp_q] ? 2'b11 : (h_slverr ? 2'b10 : 2'b00);
    end

    // Burst walker
    state_e            state_q;
    logic [ID_W-1:0]   id_q, cur_id;
    logic [MEM_AW-1:0] addr_q, cur_addr, next_addr, addr_inc, wrap_mask;
    logic [3:0]        len_q, cnt_q, cur_len, cur_cnt;
    logic [1:0]        burst_q, resp_q, cur_burst, cur_resp;
    logic              cur_last, active, issue, credit, rd_pop;
    logic [1:0]        sk_cnt_q;
    logic              v1_q;
    logic [2:0]        occ;

    assign pop    = (state_q == StIdle) && q_nempty;
    assign active = (state_q == StRun) || pop;
    assign rd_pop = s_rvalid && s_rready;
    // A beat leaving the skid buffer this cycle frees its slot for the beat issued now.
    assign occ    = 3'(sk_cnt_q) + 3'(v1_q) - 3'(rd_pop);
    assign credit = (occ < 3'd2);
    assign issue  = active && credit && !reset;

    always_comb begin
        if (state_q == StIdle) begin
            cur_id    = q_id_q[q_rp_q];
            cur_addr  = q_waddr_q[q_rp_q];
            cur_len   = h_len;
            cur_burst = h_burst;
            cur_resp  = h_resp;
            cur_cnt   = 4'd0;
        end else begin
            cur_id    = id_q;
            cur_addr  = addr_q;
            cur_len   = len_q;
            cur_burst = burst_q;
            cur_resp  = resp_q;
            cur_cnt   = cnt_q;
        end
        cur_last  = (cur_cnt == cur_len);
        addr_inc  = cur_addr + MEM_AW'(1);
        wrap_mask = MEM_AW'(cur_len);
        unique case (cur_burst)
            2'b00:   next_addr = cur_addr;
            2'b10:   next_addr = (cur_addr & ~wrap_mask) | (addr_inc & wrap_mask);
            default: next_addr = addr_inc;
        endcase
    end

    assign mem_en   = issue && (cur_resp == 2'b00);
    assign mem_addr = cur_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            resp_q  <= '0;
        end else if (active) begin
            id_q    <= cur_id;
            len_q   <= cur_len;
            burst_q <= cur_burst;
            resp_q  <= cur_resp;
            if (issue && cur_last) begin
                state_q <= StIdle;
            end else begin
                state_q <= StRun;
                addr_q  <= issue ? next_addr : cur_addr;
                cnt_q   <= issue ? cur_cnt + 4'd1 : cur_cnt;
            end
        end
    end

    // Beat in flight through the memory
    logic [ID_W-1:0] id1_q;
    logic [1:0]      resp1_q;
    logic            last1_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            id1_q   <= '0;
            resp1_q <= '0;
            last1_q <= 1'b0;
        end else begin
            v1_q    <= issue;
            id1_q   <= cur_id;
            resp1_q <= cur_resp;
            last1_q <= cur_last;
        end
    end

    // R skid buffer
    logic [ID_W-1:0] sk_id_q   [2];
    logic [31:0]     sk_data_q [2];
    logic [1:0]      sk_resp_q [2];
    logic            sk_last_q [2];
    logic            sk_wp_q, sk_rp_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                sk_id_q[i]   <= '0;
                sk_data_q[i] <= '0;
                sk_resp_q[i] <= '0;
                sk_last_q[i] <= 1'b0;
            end
            sk_wp_q  <= 1'b0;
            sk_rp_q  <= 1'b0;
            sk_cnt_q <= '0;
        end else begin
            if (v1_q) begin
                sk_id_q[sk_wp_q]   <= id1_q;
                sk_data_q[sk_wp_q] <= (resp1_q == 2'b00) ? mem_rdata : 32'h0;
                sk_resp_q[sk_wp_q] <= resp1_q;
                sk_last_q[sk_wp_q] <= last1_q;
                sk_wp_q            <= ~sk_wp_q;
            end
            if (rd_pop) sk_rp_q <= ~sk_rp_q;
            sk_cnt_q <= sk_cnt_q + 2'(v1_q) - 2'(rd_pop);
        end
    end

    assign s_rvalid = (sk_cnt_q != 2'd0);
    assign s_rid    = sk_id_q[sk_rp_q];
    assign s_rdata  = sk_data_q[sk_rp_q];
    assign s_rresp  = sk_resp_q[sk_rp_q];
    assign s_rlast  = sk_last_q[sk_rp_q];
endmodule
